// File: rtl/audio_cap_pkg.sv
// Shared types and constants for the audio sample capture block.
package audio_cap_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef struct packed {
    logic                chan;
    logic [SAMPLE_W-1:0] data;
  } entry_t;

  function automatic logic [SAMPLE_W-1:0] abs_sat(
    input logic [SAMPLE_W-1:0] w
  );
    logic [SAMPLE_W-1:0] n;
    n = -w;
    if (!w[SAMPLE_W-1]) return w;
    // -32768 has no positive twin
    if (n[SAMPLE_W-1]) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    return n;
  endfunction

endpackage

// File: rtl/audio_cap_fifo.sv
// Single-clock sample FIFO with a registered head word.
// No bypass: a push into an empty FIFO is visible one clock later.
module audio_cap_fifo
  import audio_cap_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  entry_t      wr_data,
  input  logic        rd_en,
  output entry_t      rd_data,
  output logic        rd_valid,
  output logic [AW:0] level,
  output logic        drop
);

  entry_t        mem [DEPTH];
  entry_t        head_q;
  entry_t        head_next;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_next;
  logic          full;
  logic          pop;
  logic          push_ok;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign rd_valid = (level != '0);
  assign pop      = rd_en && rd_valid;
  assign push_ok  = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;
  assign rd_next  = rd_ptr + {{AW{1'b0}}, pop};
  assign rd_data  = head_q;

  always_comb begin
    head_next = mem[rd_next[AW-1:0]];
    if (push_ok && (wr_ptr == rd_next)) head_next = wr_data;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_next;
      if (push_ok || pop) head_q <= head_next;
    end
  end

endmodule

// File: rtl/audio_sample_capture.sv
// LRCK-synchronised audio sample capture into a small FIFO.
// Optional peak meter enabled by defining AUDIO_CAP_PEAK_EN.
module audio_sample_capture
  import audio_cap_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        aud_lrck,
  input  logic [SAMPLE_W-1:0]         audiodata,
  output logic [SAMPLE_W-1:0]         sample_data,
  output logic                        sample_chan,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clear_ovf
`ifdef AUDIO_CAP_PEAK_EN
  ,
  output logic [SAMPLE_W-1:0]         peak_abs,
  input  logic                        peak_clr
`endif
);

  logic                lrck_s1;
  logic                lrck_s2;
  logic                lrck_s3;
  logic [SAMPLE_W-1:0] data_s1;
  logic [SAMPLE_W-1:0] data_s2;
  logic [1:0]          warm;
  logic                lrck_edge;
  logic                push_q;
  entry_t              push_ent;
  entry_t              head;
  logic                drop;
  logic                ovf_q;

  // edges are masked until lrck_s3 holds a genuinely sampled value
  assign lrck_edge = (&warm) && (lrck_s2 ^ lrck_s3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrck_s1  <= 1'b0;
      lrck_s2  <= 1'b0;
      lrck_s3  <= 1'b0;
      data_s1  <= '0;
      data_s2  <= '0;
      warm     <= '0;
      push_q   <= 1'b0;
      push_ent <= '0;
    end else begin
      lrck_s1  <= aud_lrck;
      lrck_s2  <= lrck_s1;
      lrck_s3  <= lrck_s2;
      data_s1  <= audiodata;
      data_s2  <= data_s1;
      if (!(&warm)) warm <= warm + 2'd1;
      push_q   <= lrck_edge;
      push_ent <= '{chan: ~lrck_s2, data: data_s2};
    end
  end

  audio_cap_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (push_q),
    .wr_data  (push_ent),
    .rd_en    (sample_ready),
    .rd_data  (head),
    .rd_valid (sample_valid),
    .level    (fifo_level),
    .drop     (drop)
  );

  assign sample_data = head.data;
  assign sample_chan = head.chan;
  assign overflow    = ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (clear_ovf) ovf_q <= 1'b0;
  end

`ifdef AUDIO_CAP_PEAK_EN
  logic [SAMPLE_W-1:0] mag;
  logic [SAMPLE_W-1:0] peak_q;

  assign mag      = abs_sat(push_ent.data);
  assign peak_abs = peak_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   peak_q <= '0;
    else if (peak_clr)              peak_q <= push_q ? mag : '0;
    else if (push_q && mag > peak_q) peak_q <= mag;
  end
`endif

endmodule

// File: tb/tb_audio_sample_capture.sv
// Self-checking bench for audio_sample_capture.
// Queue-based reference model plus directed literal checks.
module tb_audio_sample_capture;
  import audio_cap_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        aud_lrck;
  logic [15:0] audiodata;
  logic [15:0] sample_data;
  logic        sample_chan;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        clear_ovf;
`ifdef AUDIO_CAP_PEAK_EN
  logic [15:0] peak_abs;
  logic        peak_clr;
`endif

  audio_sample_capture dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .aud_lrck     (aud_lrck),
    .audiodata    (audiodata),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clear_ovf    (clear_ovf)
`ifdef AUDIO_CAP_PEAK_EN
    ,
    .peak_abs     (peak_abs),
    .peak_clr     (peak_clr)
`endif
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pin edge produces a sample 4 clocks later.
  typedef struct {
    int     due;
    entry_t e;
  } pend_t;

  pend_t  pend[$];
  entry_t q[$];
  bit     m_ovf = 1'b0;
  int     cyc = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      q.delete();
      pend.delete();
      m_ovf = 1'b0;
    end else begin
      bit dropped;
      cyc++;
      dropped = 1'b0;
      if (sample_ready && q.size() > 0) void'(q.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) begin
        pend_t p;
        p = pend.pop_front();
        if (q.size() < 8) q.push_back(p.e);
        else dropped = 1'b1;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("valid", sample_valid, q.size() != 0);
      chk("level", fifo_level, q.size());
      chk("ovf", overflow, m_ovf);
      if (q.size() != 0) begin
        chk("data", sample_data, q[0].data);
        chk("chan", sample_chan, q[0].chan);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; rising LRCK is left (0), falling is right (1).
  task automatic toggle(input logic [15:0] w);
    pend_t p;
    aud_lrck  = ~aud_lrck;
    audiodata = w;
    p.due     = cyc + 4;
    p.e.chan  = ~aud_lrck;
    p.e.data  = w;
    pend.push_back(p);
  endtask

  task automatic drain();
    sample_ready = 1'b1;
    wait_cyc(12);
    sample_ready = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    aud_lrck     = 1'b0;
    audiodata    = 16'h0;
    sample_ready = 1'b0;
    clear_ovf    = 1'b0;
`ifdef AUDIO_CAP_PEAK_EN
    peak_clr     = 1'b0;
`endif
    #35;
    chk("rst_level", fifo_level, 4'd0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_data", sample_data, 16'h0);
    chk("rst_ovf", overflow, 1'b0);
    wait_cyc(2);
    reset_n = 1'b1;
    wait_cyc(6);

    // stream with ready=1, full LRCK half-period spacing
    sample_ready = 1'b1;
    toggle(16'h1234);
    wait_cyc(3);
    chk("lat3_valid", sample_valid, 1'b0);
    wait_cyc(1);
    chk("lat4_valid", sample_valid, 1'b1);
    chk("lat4_data", sample_data, 16'h1234);
    chk("lat4_chan", sample_chan, 1'b0);
    wait_cyc(516);
    toggle(16'hABCD);
    wait_cyc(4);
    chk("r_valid", sample_valid, 1'b1);
    chk("r_data", sample_data, 16'hABCD);
    chk("r_chan", sample_chan, 1'b1);
    wait_cyc(6);
    sample_ready = 1'b0;

    // sub-clock glitch between sampling edges
    #2 aud_lrck = ~aud_lrck;
    #3 aud_lrck = ~aud_lrck;
    wait_cyc(10);
    chk("glitch_level", fifo_level, 4'd0);

    // overflow after 9 edges with no consumer
    for (int i = 0; i < 9; i++) begin
      toggle(16'h1000 + 16'(i));
      wait_cyc(8);
    end
    wait_cyc(4);
    chk("ovf_level", fifo_level, 4'd8);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_head", sample_data, 16'h1000);
    clear_ovf = 1'b1;
    wait_cyc(1);
    clear_ovf = 1'b0;
    chk("ovf_clr", overflow, 1'b0);
    drain();

    // full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) begin
      toggle(16'h2000 + 16'(i));
      wait_cyc(8);
    end
    toggle(16'h2008);
    wait_cyc(3);
    sample_ready = 1'b1;
    wait_cyc(1);
    sample_ready = 1'b0;
    chk("pp_level", fifo_level, 4'd8);
    chk("pp_ovf", overflow, 1'b0);
    chk("pp_head", sample_data, 16'h2001);
    drain();

    // head held stable while not ready
    toggle(16'h5A5A);
    wait_cyc(8);
    toggle(16'hC3C3);
    wait_cyc(100);
    chk("hold_data", sample_data, 16'h5A5A);
    chk("hold_chan", sample_chan, aud_lrck);
    chk("hold_level", fifo_level, 4'd2);

    // reset mid-stream with LRCK high
    if (!aud_lrck) begin
      toggle(16'h7777);
      wait_cyc(8);
    end
    #3 reset_n = 1'b0;
    #1;
    chk("mrst_level", fifo_level, 4'd0);
    chk("mrst_valid", sample_valid, 1'b0);
    chk("mrst_data", sample_data, 16'h0);
    chk("mrst_chan", sample_chan, 1'b0);
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(12);
    chk("mrst_nopush", fifo_level, 4'd0);
    toggle(16'h0F0F);
    wait_cyc(4);
    chk("mrst_first", sample_data, 16'h0F0F);
    chk("mrst_fchan", sample_chan, 1'b1);
    drain();

`ifdef AUDIO_CAP_PEAK_EN
    sample_ready = 1'b1;
    toggle(16'h0100);
    wait_cyc(8);
    toggle(16'h8000);
    wait_cyc(8);
    toggle(16'hFF00);
    wait_cyc(8);
    chk("peak_sat", peak_abs, 16'h7FFF);
    peak_clr = 1'b1;
    wait_cyc(1);
    peak_clr = 1'b0;
    chk("peak_clr", peak_abs, 16'h0000);
    toggle(16'h0010);
    wait_cyc(8);
    chk("peak_new", peak_abs, 16'h0010);
    sample_ready = 1'b0;
`endif

    wait_cyc(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
